// File: rtl/nvme_cmpl_poll_pkg.sv
// Shared definitions for the NVMe completion poller: tracker entry layout, FSM states, watchdog limit.
package nvme_cmpl_poll_pkg;

  localparam int unsigned CMD_ACTION_ID_BITS  = 4;
  localparam int unsigned TRACK_INFO_BITS     = 2;
  localparam int unsigned TRACK_VALID_BIT     = 0;
  localparam int unsigned TRACK_ERR_BIT       = 1;
  localparam int unsigned POLL_TIMEOUT_CYCLES = 1024;
  localparam int unsigned WDOG_BITS           = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    OUT
  } poll_state_t;

endpackage

// File: rtl/nvme_rr_arb.sv
// N-way round-robin arbiter: first requester at or after i_ptr, searching upward with wrap.
module nvme_rr_arb #(
  parameter int unsigned ID_BITS = 4
) (
  input  logic [(1<<ID_BITS)-1:0] i_req,
  input  logic [ID_BITS-1:0]      i_ptr,
  output logic                    o_grant_valid,
  output logic [ID_BITS-1:0]      o_grant_id
);

  localparam int unsigned N = 1 << ID_BITS;

  logic [ID_BITS-1:0] w_idx;

  // N is a power of two, so the id add wraps naturally.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_id    = '0;
    w_idx         = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = i_ptr + ID_BITS'(i);
      if (!o_grant_valid && i_req[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_id    = w_idx;
      end
    end
  end

endmodule

// File: rtl/nvme_cmpl_poll.sv
// Round-robin poller of the I/O completion tracker; emits in-order completion records and counters.
// Optional WAIT watchdog enabled by defining POLL_TIMEOUT_EN.
module nvme_cmpl_poll
  import nvme_cmpl_poll_pkg::*;
#(
  parameter int unsigned ACTION_ID_BITS  = CMD_ACTION_ID_BITS,
  parameter int unsigned TRACK_INFO_BITS = 2,
  parameter int unsigned CNT_BITS        = 32
) (
  input  logic                         axi_aclk,
  input  logic                         axi_areset,
  input  logic                         track_init,
  input  logic [(1<<ACTION_ID_BITS)-1:0] track_status,
  input  logic [(1<<ACTION_ID_BITS)-1:0] poll_enable,
  output logic                         track_update,
  output logic [ACTION_ID_BITS-1:0]    track_update_id,
  input  logic                         track_update_done,
  input  logic [TRACK_INFO_BITS-1:0]   track_update_data,
  output logic                         cmpl_valid,
  input  logic                         cmpl_ready,
  output logic [ACTION_ID_BITS-1:0]    cmpl_action_id,
  output logic                         cmpl_error,
  output logic [CNT_BITS-1:0]          cmpl_count,
  output logic [CNT_BITS-1:0]          err_count,
  output logic                         poll_timeout
);

  poll_state_t               r_state, w_next;
  logic [ACTION_ID_BITS-1:0] r_ptr, r_id, w_grant_id;
  logic                      w_grant_valid, r_err, w_timeout_hit;
  logic [CNT_BITS-1:0]       r_cmpl_cnt, r_err_cnt;

  nvme_rr_arb #(
    .ID_BITS(ACTION_ID_BITS)
  ) u_arb (
    .i_req        (track_status & poll_enable),
    .i_ptr        (r_ptr),
    .o_grant_valid(w_grant_valid),
    .o_grant_id   (w_grant_id)
  );

`ifdef POLL_TIMEOUT_EN
  logic [WDOG_BITS-1:0] r_wdog;
  logic                 r_timeout;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset || r_state != WAIT) r_wdog <= '0;
    else                               r_wdog <= r_wdog + 1'b1;
  end

  // Fires on the 1024th WAIT cycle without a reply.
  assign w_timeout_hit = (r_state == WAIT) && !track_update_done &&
                         (r_wdog == WDOG_BITS'(POLL_TIMEOUT_CYCLES - 1));

  always_ff @(posedge axi_aclk) begin
    if (axi_areset)         r_timeout <= 1'b0;
    else if (w_timeout_hit) r_timeout <= 1'b1;
  end

  assign poll_timeout = r_timeout;
`else
  assign w_timeout_hit = 1'b0;
  assign poll_timeout  = 1'b0;
`endif

  always_comb begin
    w_next       = r_state;
    track_update = 1'b0;
    cmpl_valid   = 1'b0;
    case (r_state)
      IDLE: if (track_init && w_grant_valid) w_next = REQ;
      REQ: begin
        track_update = 1'b1;
        w_next       = WAIT;
      end
      WAIT: begin
        if (track_update_done)
          w_next = track_update_data[TRACK_VALID_BIT] ? OUT : IDLE;
        else if (w_timeout_hit)
          w_next = IDLE;
      end
      OUT: begin
        cmpl_valid = 1'b1;
        if (cmpl_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_id       <= '0;
      r_err      <= 1'b0;
      r_cmpl_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && track_init && w_grant_valid) begin
        r_id  <= w_grant_id;
        r_ptr <= w_grant_id + ACTION_ID_BITS'(1);
      end
      if (r_state == WAIT && track_update_done && track_update_data[TRACK_VALID_BIT])
        r_err <= track_update_data[TRACK_ERR_BIT];
      if (r_state == OUT && cmpl_ready) begin
        r_cmpl_cnt <= r_cmpl_cnt + 1'b1;
        if (r_err) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign track_update_id = r_id;
  assign cmpl_action_id  = r_id;
  assign cmpl_error      = r_err;
  assign cmpl_count      = r_cmpl_cnt;
  assign err_count       = r_err_cnt;

endmodule

// File: tb/tb_nvme_cmpl_poll.sv
// Self-checking bench for nvme_cmpl_poll: directed scenarios plus randomized tracker/consumer model.
module tb_nvme_cmpl_poll;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;
  logic [15:0] status, en;
  logic        upd;
  logic [3:0]  upd_id;
  logic        done;
  logic [1:0]  data;
  logic        cv, cr;
  logic [3:0]  cid;
  logic        cerr;
  logic [31:0] ccnt, ecnt;
  logic        pto;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  nvme_cmpl_poll #(
    .ACTION_ID_BITS (4),
    .TRACK_INFO_BITS(2),
    .CNT_BITS       (32)
  ) dut (
    .axi_aclk         (clk),
    .axi_areset       (rst),
    .track_init       (init),
    .track_status     (status),
    .poll_enable      (en),
    .track_update     (upd),
    .track_update_id  (upd_id),
    .track_update_done(done),
    .track_update_data(data),
    .cmpl_valid       (cv),
    .cmpl_ready       (cr),
    .cmpl_action_id   (cid),
    .cmpl_error       (cerr),
    .cmpl_count       (ccnt),
    .err_count        (ecnt),
    .poll_timeout     (pto)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; init = 1'b0; status = '0; en = '0; done = 1'b0; data = '0; cr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_update(output bit found, output logic [3:0] id);
    found = 1'b0;
    id    = '0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (upd) begin
        found = 1'b1;
        id    = upd_id;
        break;
      end
    end
  endtask

  task automatic reply(input int d, input logic [1:0] dat);
    repeat (d) tick();
    done = 1'b1; data = dat;
    tick();
    done = 1'b0; data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b1; status = '1; en = '1; done = 1'b0; data = '0; cr = 1'b1;
    repeat (4) tick();
    nvec++;
    if ({upd, upd_id, cv, cid, cerr} !== 11'h0) begin
      nerr++; $display("FAIL reset_outputs got=%0h exp=0", {upd, upd_id, cv, cid, cerr});
    end
    nvec++;
    if (ccnt !== 32'd0 || ecnt !== 32'd0) begin
      nerr++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", ccnt, ecnt);
    end
    nvec++;
    if (pto !== 1'b0) begin
      nerr++; $display("FAIL reset_timeout got=%0b exp=0", pto);
    end
    rst = 1'b0;
  endtask

  task automatic test_no_init();
    int cnt;
    bit f;
    logic [3:0] id;
    do_reset();
    status = 16'h0001; en = '1; cr = 1'b1; init = 1'b0;
    cnt = 0;
    repeat (100) begin
      tick();
      if (upd) cnt++;
    end
    nvec++;
    if (cnt !== 0) begin
      nerr++; $display("FAIL no_init_updates got=%0d exp=0", cnt);
    end
    init = 1'b1;
    wait_update(f, id);
    nvec++;
    if (!f || id !== 4'd0) begin
      nerr++; $display("FAIL init_first_poll got=%0b/%0d exp=1/0", f, id);
    end
  endtask

  task automatic test_single();
    bit f;
    logic [3:0] id;
    do_reset();
    init = 1'b1; en = '1; status = 16'h0008;
    wait_update(f, id);
    nvec++;
    if (!f || id !== 4'd3) begin
      nerr++; $display("FAIL single_grant got=%0b/%0d exp=1/3", f, id);
    end
    status = '0;
    reply(3, 2'b01);
    nvec++;
    if ({cv, cid, cerr} !== {1'b1, 4'd3, 1'b0} || ccnt !== 32'd0) begin
      nerr++; $display("FAIL single_record got=%0b/%0d/%0b cnt=%0d exp=1/3/0 cnt=0", cv, cid, cerr, ccnt);
    end
    cr = 1'b1; tick(); cr = 1'b0;
    nvec++;
    if (cv !== 1'b0 || ccnt !== 32'd1 || ecnt !== 32'd0) begin
      nerr++; $display("FAIL single_count got=%0b/%0d/%0d exp=0/1/0", cv, ccnt, ecnt);
    end
  endtask

  task automatic test_error();
    bit f;
    int nv;
    logic [3:0] id;
    do_reset();
    init = 1'b1; en = '1; status = 16'h0020;
    wait_update(f, id);
    status = '0;
    reply(2, 2'b11);
    nvec++;
    if ({cv, cid, cerr} !== {1'b1, 4'd5, 1'b1}) begin
      nerr++; $display("FAIL error_record got=%0b/%0d/%0b exp=1/5/1", cv, cid, cerr);
    end
    cr = 1'b1; tick(); cr = 1'b0;
    nvec++;
    if (ccnt !== 32'd1 || ecnt !== 32'd1) begin
      nerr++; $display("FAIL error_count got=%0d/%0d exp=1/1", ccnt, ecnt);
    end
    status = 16'h0040;
    wait_update(f, id);
    status = '0;
    reply(4, 2'b00);
    nv = 0;
    repeat (10) begin
      tick();
      if (cv) nv++;
    end
    nvec++;
    if (nv !== 0 || ccnt !== 32'd1 || ecnt !== 32'd1) begin
      nerr++; $display("FAIL cleared_reply got=%0d/%0d/%0d exp=0/1/1", nv, ccnt, ecnt);
    end
    status = 16'h0002;
    wait_update(f, id);
    nvec++;
    if (!f || id !== 4'd1) begin
      nerr++; $display("FAIL after_cleared_poll got=%0b/%0d exp=1/1", f, id);
    end
  endtask

  task automatic test_done_in_req();
    bit f;
    int nv;
    logic [3:0] id;
    do_reset();
    init = 1'b1; en = '1; status = 16'h0010;
    wait_update(f, id);
    status = '0;
    done = 1'b1; data = 2'b01;
    tick();
    done = 1'b0; data = '0;
    nv = 0;
    repeat (5) begin
      tick();
      if (cv) nv++;
    end
    nvec++;
    if (nv !== 0) begin
      nerr++; $display("FAIL done_in_req_ignored got=%0d exp=0", nv);
    end
    reply(1, 2'b01);
    nvec++;
    if ({cv, cid, cerr} !== {1'b1, 4'd4, 1'b0}) begin
      nerr++; $display("FAIL done_after_req got=%0b/%0d/%0b exp=1/4/0", cv, cid, cerr);
    end
  endtask

  task automatic test_order();
    int exp_ids[6] = '{0, 2, 15, 0, 2, 15};
    bit f;
    logic [3:0] id;
    do_reset();
    init = 1'b1; en = '1; status = 16'h8005; cr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_update(f, id);
      nvec++;
      if (!f || id !== 4'(exp_ids[k])) begin
        nerr++; $display("FAIL order_grant%0d got=%0b/%0d exp=1/%0d", k, f, id, exp_ids[k]);
      end
      reply($urandom_range(1, 4), 2'b01);
    end
    tick();
    nvec++;
    if (ccnt !== 32'd6) begin
      nerr++; $display("FAIL order_count got=%0d exp=6", ccnt);
    end
  endtask

  task automatic test_backpressure();
    bit f;
    logic [3:0] id;
    do_reset();
    init = 1'b1; en = '1; status = 16'h0002; cr = 1'b0;
    wait_update(f, id);
    reply(1, 2'b11);
    for (int c = 0; c < 20; c++) begin
      nvec++;
      if ({cv, cid, cerr, upd} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
        nerr++; $display("FAIL stall_cycle%0d got=%0b/%0d/%0b upd=%0b exp=1/1/1 upd=0", c, cv, cid, cerr, upd);
      end
      tick();
    end
    status = '0; cr = 1'b1; tick(); cr = 1'b0;
    nvec++;
    if (cv !== 1'b0 || ccnt !== 32'd1 || ecnt !== 32'd1) begin
      nerr++; $display("FAIL stall_release got=%0b/%0d/%0d exp=0/1/1", cv, ccnt, ecnt);
    end
  endtask

`ifdef POLL_TIMEOUT_EN
  task automatic test_timeout();
    bit f;
    int n;
    logic [3:0] id;
    do_reset();
    init = 1'b1; en = '1; status = 16'h0001; cr = 1'b1;
    wait_update(f, id);
    n = 0;
    while (pto !== 1'b1 && n < 1200) begin
      tick();
      n++;
    end
    nvec++;
    if (n !== 1025) begin
      nerr++; $display("FAIL timeout_latency got=%0d exp=1025", n);
    end
    wait_update(f, id);
    nvec++;
    if (!f || id !== 4'd0 || pto !== 1'b1) begin
      nerr++; $display("FAIL timeout_next_poll got=%0b/%0d/%0b exp=1/0/1", f, id, pto);
    end
    status = '0;
    reply(2, 2'b01);
    nvec++;
    if ({cv, cid} !== {1'b1, 4'd0}) begin
      nerr++; $display("FAIL timeout_recovery got=%0b/%0d exp=1/0", cv, cid);
    end
  endtask
`endif

  task automatic test_random();
    int         pend[16];
    int         mptr, cd, gexp, nrec, nerrrec, j;
    bit         prev_upd, stop, any_pend, any_elig, e;
    logic [3:0] rid;
    logic [4:0] expq[$];
    logic [4:0] r;
    do_reset();
    init = 1'b1; en = '1;
    foreach (pend[i]) pend[i] = 0;
    for (int i = 0; i < 6; i++) pend[$urandom_range(0, 15)] += 1;
    foreach (pend[i]) status[i] = (pend[i] != 0);
    mptr = 0; cd = -1; nrec = 0; nerrrec = 0; prev_upd = 1'b0; rid = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      done = 1'b0; data = '0;
      stop = (cyc >= 2500);
      if (upd) begin
        nvec++;
        if (prev_upd) begin
          nerr++; $display("FAIL update_back_to_back cyc=%0d got=1 exp=0", cyc);
        end
        gexp = -1;
        for (int i = 0; i < 16; i++) begin
          j = (mptr + i) % 16;
          if (gexp < 0 && pend[j] > 0 && en[j]) gexp = j;
        end
        nvec++;
        if (gexp < 0 || upd_id !== 4'(gexp)) begin
          nerr++; $display("FAIL rand_grant cyc=%0d got=%0d exp=%0d", cyc, upd_id, gexp);
        end
        rid  = upd_id;
        mptr = (int'(rid) + 1) % 16;
        cd   = $urandom_range(1, 4);
        if (!stop) begin
          for (int k = $urandom_range(0, 2); k > 0; k--) pend[$urandom_range(0, 15)] += 1;
          if ($urandom_range(0, 3) == 0) en = 16'($urandom);
        end
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          cd   = -1;
          done = 1'b1;
          if ($urandom_range(0, 5) == 0) begin
            pend[rid] = 0;
            data = 2'b00;
          end else begin
            e = 1'($urandom_range(0, 1));
            if (pend[rid] > 0) pend[rid]--;
            data = {e, 1'b1};
            expq.push_back({rid, e});
          end
        end
      end
      prev_upd = upd;
      any_pend = 1'b0; any_elig = 1'b0;
      foreach (pend[i]) begin
        if (pend[i] > 0) any_pend = 1'b1;
        if (pend[i] > 0 && en[i]) any_elig = 1'b1;
      end
      if (any_pend && !any_elig) en = '1;
      if (!any_pend && !stop) pend[$urandom_range(0, 15)] += 1;
      cr = ($urandom_range(0, 3) != 0);
      if (cv && cr) begin
        nvec++;
        if (expq.size() == 0) begin
          nerr++; $display("FAIL rand_unexpected_record got=%0d/%0b exp=none", cid, cerr);
        end else begin
          r = expq.pop_front();
          if ({cid, cerr} !== r) begin
            nerr++; $display("FAIL rand_record got=%0d/%0b exp=%0d/%0b", cid, cerr, r[4:1], r[0]);
          end
          nrec++;
          if (r[0]) nerrrec++;
        end
      end
      foreach (pend[i]) status[i] = (pend[i] != 0);
      if (stop && !any_pend && cd < 0 && expq.size() == 0 && !cv && !upd) break;
    end
    cr = 1'b0;
    tick(); tick();
    nvec++;
    if (expq.size() != 0 || ccnt !== 32'(nrec) || ecnt !== 32'(nerrrec)) begin
      nerr++; $display("FAIL rand_totals got=left%0d/%0d/%0d exp=left0/%0d/%0d", expq.size(), ccnt, ecnt, nrec, nerrrec);
    end
  endtask

  initial begin
    test_reset();
    test_no_init();
    test_single();
    test_error();
    test_done_in_req();
    test_order();
    test_backpressure();
`ifdef POLL_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit got=expired exp=finished");
    $fatal(1);
  end

endmodule
